// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC router output-port arbiter.
package noc_pkg;

    localparam int PKT_W = 9;
    localparam int NREQ  = 5;
    localparam int IDX_W = 3;

    typedef struct packed {
        logic       rsvd;
        logic [1:0] x_dest;
        logic [1:0] y_dest;
        logic [3:0] payload;
    } packet_t;

    typedef enum logic [IDX_W-1:0] {
        PORT_N,
        PORT_E,
        PORT_S,
        PORT_W,
        PORT_L
    } port_e;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NREQ-1)) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/noc_port_arbiter_rr_pick.sv
// Combinational round-robin picker: doubled request vector, mask below ptr,
// lowest set bit wins and folds back into 0..NREQ-1.
module rr_pick
    import noc_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [2*NREQ-1:0] masked;
    logic              found;

    always_comb begin
        masked  = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < 2*NREQ; i++) begin
            if (i >= int'(ptr)) masked[i] = req[i % NREQ];
        end
        for (int i = 0; i < 2*NREQ; i++) begin
            if (masked[i] && !found) begin
                found   = 1'b1;
                gnt_idx = (i >= NREQ) ? IDX_W'(i - NREQ) : IDX_W'(i);
            end
        end
        any = |req;
        gnt = any ? (NREQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter feeding one registered output slot of a mesh router.
// Optional per-requester grant and stall counters under NOC_ARB_STATS_EN.
module noc_port_arbiter
    import noc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       in_valid,
    input  logic [NREQ*PKT_W-1:0] in_data,
    output logic [NREQ-1:0]       in_ready,
    output logic                  out_valid,
    output logic [PKT_W-1:0]      out_data,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_src
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]    grant_count,
    output logic [15:0]           stall_cycles
`endif
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [NREQ-1:0]  gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             any;
    logic             slot_free;
    logic             take;
    packet_t          slot;
    port_e            src_q;

    rr_pick u_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // in_ready is held low while reset is asserted
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        slot_free = (state == EMPTY) || out_ready;
        take      = rst_n && slot_free && any;
        in_ready  = take ? gnt : '0;
        if (take) begin
            state_nxt = FULL;
            ptr_nxt   = idx_inc(gnt_idx);
        end else if (state == FULL && out_ready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            ptr   <= '0;
            slot  <= '0;
            src_q <= PORT_N;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (take) begin
                slot  <= packet_t'(in_data[gnt_idx*PKT_W +: PKT_W]);
                src_q <= port_e'(gnt_idx);
            end
        end
    end

    assign out_valid = (state == FULL);
    assign out_data  = slot;
    assign out_src   = src_q;

`ifdef NOC_ARB_STATS_EN
    logic [15:0] gcnt [NREQ];
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) gcnt[i] <= '0;
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (in_ready[i] && in_valid[i] && gcnt[i] != 16'hFFFF)
                    gcnt[i] <= gcnt[i] + 16'd1;
            end
            if (out_valid && !out_ready && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NREQ; i++) grant_count[i*16 +: 16] = gcnt[i];
    end

    assign stall_cycles = stall_q;
`endif

endmodule
